// File: rtl/hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: load-use bubbles, branch flushes,
// and a watchdog-guarded freeze while a multi-cycle data-memory access is outstanding.
module hazard_ctrl #(
    parameter int TIMEOUT = 256,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs1_address,
    input  logic [4:0]       id_rs2_address,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic [4:0]       ex_rd_address,
    input  logic             ex_mem_read,
    input  logic             ex_branch_taken,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             id_ex_write,
    output logic             ex_mem_write,
    output logic             id_ex_bubble,
    output logic             if_id_flush,
    output logic             mem_wb_bubble,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    localparam int WC_W = $clog2(TIMEOUT) + 1;

    typedef enum logic [1:0] {
        S_RUN,
        S_MEM_WAIT,
        S_TIMEOUT
    } state_t;

    state_t            state_q, state_d;
    logic [WC_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic              pending_flush_q, pending_flush_d;
    logic              mem_timeout_q, mem_timeout_d;
    logic [CNT_W-1:0]  stall_count_q, stall_count_d;
    logic [CNT_W-1:0]  flush_count_q, flush_count_d;

    logic load_use;
    logic mem_busy;
    logic freeze;
    logic use_run;
    logic flush_term;

    assign load_use = ex_mem_read && (ex_rd_address != 5'd0) &&
                      ((id_uses_rs1 && (id_rs1_address == ex_rd_address)) ||
                       (id_uses_rs2 && (id_rs2_address == ex_rd_address)));
    assign mem_busy = dmem_req && !dmem_ready;

    always_comb begin
        state_d         = state_q;
        wait_cnt_d      = wait_cnt_q;
        pending_flush_d = pending_flush_q;
        mem_timeout_d   = mem_timeout_q;
        freeze          = 1'b0;
        use_run         = 1'b0;
        flush_term      = ex_branch_taken;

        case (state_q)
            S_RUN: begin
                if (mem_busy) begin
                    // A redirect seen while freezing is remembered and applied on release.
                    freeze          = 1'b1;
                    state_d         = S_MEM_WAIT;
                    wait_cnt_d      = WC_W'(1);
                    pending_flush_d = ex_branch_taken;
                end else begin
                    use_run = 1'b1;
                end
            end
            S_MEM_WAIT: begin
                if (mem_busy) begin
                    freeze     = 1'b1;
                    wait_cnt_d = wait_cnt_q + WC_W'(1);
                    if (wait_cnt_d >= WC_W'(TIMEOUT - 1)) begin
                        state_d       = S_TIMEOUT;
                        mem_timeout_d = 1'b1;
                    end
                end else begin
                    // Completion or abandoned request both release the freeze.
                    use_run         = 1'b1;
                    flush_term      = ex_branch_taken || pending_flush_q;
                    state_d         = S_RUN;
                    pending_flush_d = 1'b0;
                    wait_cnt_d      = '0;
                end
            end
            S_TIMEOUT: begin
                freeze        = 1'b1;
                mem_timeout_d = 1'b1;
            end
            default: begin
                state_d = S_RUN;
            end
        endcase

        pc_write      = 1'b1;
        if_id_write   = 1'b1;
        id_ex_write   = 1'b1;
        ex_mem_write  = 1'b1;
        id_ex_bubble  = 1'b0;
        if_id_flush   = 1'b0;
        mem_wb_bubble = 1'b0;

        if (!rst_n) begin
            // Pipeline runs freely while held in reset.
        end else if (freeze) begin
            pc_write      = 1'b0;
            if_id_write   = 1'b0;
            id_ex_write   = 1'b0;
            ex_mem_write  = 1'b0;
            mem_wb_bubble = 1'b1;
        end else if (use_run) begin
            if (flush_term) begin
                if_id_flush  = 1'b1;
                id_ex_bubble = 1'b1;
            end else if (load_use) begin
                pc_write     = 1'b0;
                if_id_write  = 1'b0;
                id_ex_bubble = 1'b1;
            end
        end

        stall_count_d = stall_count_q;
        if (!pc_write && (stall_count_q != {CNT_W{1'b1}})) begin
            stall_count_d = stall_count_q + CNT_W'(1);
        end
        flush_count_d = flush_count_q;
        if (if_id_flush && (flush_count_q != {CNT_W{1'b1}})) begin
            flush_count_d = flush_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q         <= S_RUN;
            wait_cnt_q      <= '0;
            pending_flush_q <= 1'b0;
            mem_timeout_q   <= 1'b0;
            stall_count_q   <= '0;
            flush_count_q   <= '0;
        end else begin
            state_q         <= state_d;
            wait_cnt_q      <= wait_cnt_d;
            pending_flush_q <= pending_flush_d;
            mem_timeout_q   <= mem_timeout_d;
            stall_count_q   <= stall_count_d;
            flush_count_q   <= flush_count_d;
        end
    end

    assign mem_timeout = mem_timeout_q;
    assign stall_count = stall_count_q;
    assign flush_count = flush_count_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: a default instance plus a TIMEOUT=4, 3-bit-counter
// instance sharing the same stimulus for watchdog and saturation cases.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] id_rs1_address, id_rs2_address, ex_rd_address;
    logic       id_uses_rs1, id_uses_rs2, ex_mem_read, ex_branch_taken;
    logic       dmem_req, dmem_ready;

    logic        pc_write, if_id_write, id_ex_write, ex_mem_write;
    logic        id_ex_bubble, if_id_flush, mem_wb_bubble, mem_timeout;
    logic [31:0] stall_count, flush_count;

    logic        t_pc_write, t_if_id_write, t_id_ex_write, t_ex_mem_write;
    logic        t_id_ex_bubble, t_if_id_flush, t_mem_wb_bubble, t_mem_timeout;
    logic [2:0]  t_stall_count, t_flush_count;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    hazard_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs1_address(id_rs1_address), .id_rs2_address(id_rs2_address),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .ex_rd_address(ex_rd_address), .ex_mem_read(ex_mem_read),
        .ex_branch_taken(ex_branch_taken), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .pc_write(pc_write), .if_id_write(if_id_write), .id_ex_write(id_ex_write),
        .ex_mem_write(ex_mem_write), .id_ex_bubble(id_ex_bubble), .if_id_flush(if_id_flush),
        .mem_wb_bubble(mem_wb_bubble), .mem_timeout(mem_timeout),
        .stall_count(stall_count), .flush_count(flush_count)
    );

    hazard_ctrl #(.TIMEOUT(4), .CNT_W(3)) dut_to (
        .clk(clk), .rst_n(rst_n),
        .id_rs1_address(id_rs1_address), .id_rs2_address(id_rs2_address),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .ex_rd_address(ex_rd_address), .ex_mem_read(ex_mem_read),
        .ex_branch_taken(ex_branch_taken), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .pc_write(t_pc_write), .if_id_write(t_if_id_write), .id_ex_write(t_id_ex_write),
        .ex_mem_write(t_ex_mem_write), .id_ex_bubble(t_id_ex_bubble), .if_id_flush(t_if_id_flush),
        .mem_wb_bubble(t_mem_wb_bubble), .mem_timeout(t_mem_timeout),
        .stall_count(t_stall_count), .flush_count(t_flush_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end else begin
            $display("ok   %s = %0d", tag, got);
        end
    endtask

    task automatic idle();
        id_rs1_address  = 5'd0;
        id_rs2_address  = 5'd0;
        id_uses_rs1     = 1'b0;
        id_uses_rs2     = 1'b0;
        ex_rd_address   = 5'd0;
        ex_mem_read     = 1'b0;
        ex_branch_taken = 1'b0;
        dmem_req        = 1'b0;
        dmem_ready      = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_load_use(input logic [4:0] rd, input logic [4:0] rs1, input logic u1);
        ex_mem_read    = 1'b1;
        ex_rd_address  = rd;
        id_rs1_address = rs1;
        id_uses_rs1    = u1;
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        @(posedge clk);
        #1;
        // Reset cycle with hazards present: outputs must stay in the free-running state.
        set_load_use(5'd5, 5'd5, 1'b1);
        dmem_req = 1'b1;
        #1;
        check("rst_pc_write", pc_write, 1);
        check("rst_ex_mem_write", ex_mem_write, 1);
        check("rst_id_ex_bubble", id_ex_bubble, 0);
        check("rst_mem_wb_bubble", mem_wb_bubble, 0);
        tick();
        rst_n = 1'b1;
        idle();
        #1;
        check("post_rst_stall_count", stall_count, 0);
        check("post_rst_flush_count", flush_count, 0);
        check("post_rst_mem_timeout", mem_timeout, 0);
        check("post_rst_pc_write", pc_write, 1);

        // Load-use on rs1
        set_load_use(5'd5, 5'd5, 1'b1);
        #1;
        check("lu_pc_write", pc_write, 0);
        check("lu_if_id_write", if_id_write, 0);
        check("lu_id_ex_write", id_ex_write, 1);
        check("lu_id_ex_bubble", id_ex_bubble, 1);
        check("lu_if_id_flush", if_id_flush, 0);
        tick();
        check("lu_stall_count", stall_count, 1);
        idle();
        #1;
        check("lu_cleared_pc_write", pc_write, 1);

        // No stall: rd = x0, or rs1 not used
        set_load_use(5'd0, 5'd0, 1'b1);
        #1;
        check("x0_pc_write", pc_write, 1);
        check("x0_id_ex_bubble", id_ex_bubble, 0);
        set_load_use(5'd5, 5'd5, 1'b0);
        #1;
        check("unused_rs1_pc_write", pc_write, 1);
        // Hazard on rs2
        id_rs1_address = 5'd3;
        id_uses_rs2    = 1'b1;
        id_rs2_address = 5'd5;
        #1;
        check("rs2_pc_write", pc_write, 0);
        tick();
        check("rs2_stall_count", stall_count, 2);
        idle();

        // Branch beats load-use
        set_load_use(5'd7, 5'd7, 1'b1);
        ex_branch_taken = 1'b1;
        #1;
        check("br_if_id_flush", if_id_flush, 1);
        check("br_id_ex_bubble", id_ex_bubble, 1);
        check("br_pc_write", pc_write, 1);
        check("br_if_id_write", if_id_write, 1);
        tick();
        check("br_flush_count", flush_count, 1);
        check("br_stall_count", stall_count, 2);
        idle();

        // Memory freeze: 3 waiting cycles then ready
        dmem_req = 1'b1;
        #1;
        check("mw0_pc_write", pc_write, 0);
        check("mw0_id_ex_write", id_ex_write, 0);
        check("mw0_ex_mem_write", ex_mem_write, 0);
        check("mw0_mem_wb_bubble", mem_wb_bubble, 1);
        tick();
        check("mw1_if_id_write", if_id_write, 0);
        tick();
        check("mw2_ex_mem_write", ex_mem_write, 0);
        tick();
        dmem_ready = 1'b1;
        #1;
        check("mw3_pc_write", pc_write, 1);
        check("mw3_ex_mem_write", ex_mem_write, 1);
        check("mw3_mem_wb_bubble", mem_wb_bubble, 0);
        tick();
        check("mw_stall_count", stall_count, 5);
        idle();

        // Branch during freeze entry is deferred to the ready cycle
        dmem_req = 1'b1;
        ex_branch_taken = 1'b1;
        #1;
        check("pf0_if_id_flush", if_id_flush, 0);
        check("pf0_pc_write", pc_write, 0);
        tick();
        ex_branch_taken = 1'b0;
        #1;
        check("pf1_if_id_flush", if_id_flush, 0);
        tick();
        dmem_ready = 1'b1;
        #1;
        check("pf2_if_id_flush", if_id_flush, 1);
        check("pf2_id_ex_bubble", id_ex_bubble, 1);
        check("pf2_pc_write", pc_write, 1);
        tick();
        check("pf_flush_count", flush_count, 2);
        check("pf_stall_count", stall_count, 7);
        idle();
        #1;
        check("pf3_if_id_flush", if_id_flush, 0);

        // Abandoned request releases the freeze
        dmem_req = 1'b1;
        tick();
        dmem_req = 1'b0;
        #1;
        check("ab_pc_write", pc_write, 1);
        tick();
        check("ab_stall_count", stall_count, 8);

        // Watchdog on the TIMEOUT=4 instance
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
        check("to_rst_mem_timeout", t_mem_timeout, 0);
        check("to_rst_stall_count", t_stall_count, 0);
        dmem_req = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            #1;
            check($sformatf("to_c%0d_mem_timeout", c), t_mem_timeout, 0);
            tick();
        end
        check("to_c4_mem_timeout", t_mem_timeout, 1);
        check("to_c4_pc_write", t_pc_write, 0);
        check("to_c4_mem_wb_bubble", t_mem_wb_bubble, 1);
        check("to_c4_default_inst_mem_timeout", mem_timeout, 0);
        dmem_req = 1'b0;
        for (int c = 0; c < 5; c++) tick();
        check("to_sticky_mem_timeout", t_mem_timeout, 1);
        check("to_sticky_pc_write", t_pc_write, 0);
        check("to_sat_stall_count", t_stall_count, 7);
        rst_n = 1'b0;
        dmem_req = 1'b1;
        #1;
        check("to_in_rst_pc_write", t_pc_write, 1);
        tick();
        rst_n = 1'b1;
        idle();
        #1;
        check("to_clr_mem_timeout", t_mem_timeout, 0);
        check("to_clr_pc_write", t_pc_write, 1);
        check("to_clr_stall_count", t_stall_count, 0);

        // Reset mid-freeze drops the pending flush
        dmem_req = 1'b1;
        ex_branch_taken = 1'b1;
        tick();
        ex_branch_taken = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        dmem_ready = 1'b1;
        #1;
        check("rmf_if_id_flush", if_id_flush, 0);
        check("rmf_pc_write", pc_write, 1);
        idle();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
